// File: rtl/mask_pkg.sv
// mask_pkg: shared constants and helpers for the masked S-box controller.
//   SHARES_DEF / LAT_DEF : default share count and core enable-latency
//   nz_f / r_bits_f / nb_f : multiplier randomness pairs, total random bits, LFSR bank size
//   LFSR_POLY / seed_f / lfsr_step_f : Galois LFSR x^32+x^22+x^2+x+1 and per-entry seeds
package mask_pkg;

    localparam int unsigned SHARES_DEF = 3;
    localparam int unsigned LAT_DEF    = 7;

    // Right-shift Galois feedback mask for x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef logic [7:0] byte_t;

    // Random pairs per shared multiplier
    function automatic int unsigned nz_f(input int unsigned shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Total random bits: share masks plus multiplier randomness
    function automatic int unsigned r_bits_f(input int unsigned shares, input int unsigned nz);
        return (shares - 1) * 8 + 18 * nz;
    endfunction

    // Number of 32-bit LFSRs needed to cover r random bits
    function automatic int unsigned nb_f(input int unsigned r);
        return (r + 31) / 32;
    endfunction

    // Distinct non-zero seed per bank entry (odd stride keeps them distinct)
    function automatic logic [31:0] seed_f(input int unsigned idx);
        logic [31:0] s;
        s = 32'hACE1_0001 + 32'(idx) * 32'h9E37_79B9;
        if (s == 32'h0) s = 32'h0000_0001;
        return s;
    endfunction

    function automatic logic [31:0] lfsr_step_f(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/mask_lfsr32.sv
// mask_lfsr32: one 32-bit Galois LFSR of the masking randomness bank.
//   clk, reset      : clock, asynchronous active-high reset (loads SEED)
//   step_i          : advance one step this cycle
//   reseed_i        : XOR reseed_data_i into the (possibly stepped) state
//   reseed_data_i   : entropy word
//   state_o         : current state
module mask_lfsr32
    import mask_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_i,
    input  logic        reseed_i,
    input  logic [31:0] reseed_data_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q, state_d, stepped;

    // Step first, then fold in entropy; an all-zero result would lock up, so reload the seed
    always_comb begin
        stepped = step_i ? lfsr_step_f(state_q) : state_q;
        state_d = stepped;
        if (reseed_i) begin
            state_d = stepped ^ reseed_data_i;
            if (state_d == 32'h0) state_d = SEED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= SEED;
        else       state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/sbox_mask_ctrl.sv
// sbox_mask_ctrl: handshake, mode and masking controller around an external
// masked AES S-box core with a fixed enable-latency of LAT.
//   in_valid/in_ready/in_data/in_decrypt : unmasked byte request (in_decrypt=1 -> inverse S-box)
//   out_valid/out_ready/out_data         : unmasked result (XOR of core output shares)
//   core_en/core_decrypt/core_x/core_q   : masked core pipeline control and shares
//   core_zm/core_zi                      : fresh multiplier randomness
//   reseed_valid/reseed_data             : entropy injection into the LFSR bank
// Optional feature: define MASK_PRNG_EN to build the LFSR randomness bank;
// otherwise all randomness is zero and the reseed ports are ignored.
module sbox_mask_ctrl
    import mask_pkg::*;
#(
    parameter int unsigned SHARES = SHARES_DEF,
    parameter int unsigned LAT    = LAT_DEF,
    parameter int unsigned NZ     = nz_f(SHARES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_decrypt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                core_en,
    output logic                core_decrypt,
    output logic [SHARES*8-1:0] core_x,
    input  logic [SHARES*8-1:0] core_q,
    output logic [3*NZ*4-1:0]   core_zm,
    output logic [3*NZ*2-1:0]   core_zi,
    input  logic                reseed_valid,
    input  logic [31:0]         reseed_data
);

    localparam int unsigned R   = r_bits_f(SHARES, NZ);
    localparam int unsigned SW  = (SHARES - 1) * 8;
    localparam int unsigned ZMW = 3 * NZ * 4;
    localparam int unsigned ZIW = 3 * NZ * 2;

    logic [LAT-1:0] vld_q, vld_d;
    logic           mode_q, mode_d;
    logic           accept;
    logic [R-1:0]   rnd;

    // Pipeline occupancy and mode: the core stalls only when the finished item is not taken
    always_comb begin
        core_en  = !(vld_q[LAT-1] && !out_ready);
        in_ready = core_en && (in_decrypt == mode_q);
        accept   = in_valid && in_ready;
        vld_d    = vld_q;
        mode_d   = mode_q;
        if (core_en) vld_d = (vld_q << 1) | LAT'(accept);
        // Switch direction only once the pipe has drained; costs one idle cycle
        if (in_valid && (in_decrypt != mode_q) && (vld_q == '0)) mode_d = in_decrypt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    assign out_valid    = vld_q[LAT-1];
    assign core_decrypt = mode_q;

    // Unmask the core result
    always_comb begin
        out_data = 8'h00;
        for (int unsigned k = 0; k < SHARES; k++) out_data ^= core_q[8*k +: 8];
    end

    // Split the request into shares; bubbles carry a masked zero
    always_comb begin
        core_x      = '0;
        core_x[7:0] = accept ? in_data : 8'h00;
        for (int unsigned k = 1; k < SHARES; k++) begin
            core_x[8*k +: 8] = rnd[8*(k-1) +: 8];
            core_x[7:0]     ^= rnd[8*(k-1) +: 8];
        end
    end

    assign core_zm = rnd[SW +: ZMW];
    assign core_zi = rnd[SW + ZMW +: ZIW];

`ifdef MASK_PRNG_EN
    localparam int unsigned NB  = nb_f(R);
    localparam int unsigned RSW = (NB > 1) ? $clog2(NB) : 1;

    logic [RSW-1:0]   rs_idx_q, rs_idx_d;
    logic [32*NB-1:0] bank;

    // Round-robin target for reseed words
    always_comb begin
        rs_idx_d = rs_idx_q;
        if (reseed_valid) rs_idx_d = (32'(rs_idx_q) == NB - 1) ? '0 : rs_idx_q + RSW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rs_idx_q <= '0;
        else       rs_idx_q <= rs_idx_d;
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        mask_lfsr32 #(.SEED(seed_f(b))) u_lfsr (
            .clk          (clk),
            .reset        (reset),
            .step_i       (core_en),
            .reseed_i     (reseed_valid && (32'(rs_idx_q) == 32'(b))),
            .reseed_data_i(reseed_data),
            .state_o      (bank[32*b +: 32])
        );
    end

    assign rnd = bank[R-1:0];

    if (32 * NB > R) begin : g_spare
        logic unused_bank;
        assign unused_bank = ^bank[32*NB-1:R];
    end
`else
    logic unused_reseed;
    assign unused_reseed = ^{reseed_valid, reseed_data};
    assign rnd = '0;
`endif

endmodule
